falafel_req_dispatcher: RTL and testbench
=========================================

# falafel_req_dispatcher

Drains the alloc and free request FIFOs filled by the input arbiter and issues one request at a time to the allocator core over a valid/ready channel. Arbitrates fairly between the two FIFOs and normalises alloc sizes to the allocation granule. Filters trivial requests: zero-size allocs and NULL frees never reach the core. Returns alloc results, carrying the original message ID, to the output path.

## Interface
- DATA_W, package constant: width of the size and address fields.
- MSG_ID_SIZE, package constant: width of the request ID.
- ALIGN_BYTES, default 8, power of two: allocation granule.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- alloc_fifo_empty_i  in  1  alloc FIFO empty; FIFO is first-word-fall-through.
- alloc_fifo_pop_o  out  1  consumes the alloc FIFO head.
- alloc_fifo_dout_size_i  in  DATA_W  head request size, in bytes.
- alloc_fifo_dout_id_i  in  MSG_ID_SIZE  head request ID.
- free_fifo_empty_i  in  1  free FIFO empty; FIFO is first-word-fall-through.
- free_fifo_pop_o  out  1  consumes the free FIFO head.
- free_fifo_dout_i  in  DATA_W  head address to free.
- core_req_val_o  out  1  request valid.
- core_req_rdy_i  in  1  core accepts the request.
- core_req_o  out  core_req_t  {op, data, id}.
- core_rsp_val_i  in  1  core response valid.
- core_rsp_rdy_o  out  1  dispatcher accepts the response.
- core_rsp_addr_i  in  DATA_W  allocated address; ignored for free.
- core_rsp_ok_i  in  1  allocation succeeded.
- resp_val_o  out  1  alloc result valid.
- resp_rdy_i  in  1  downstream accepts the result.
- resp_addr_o  out  DATA_W  allocated address; 0 means failure.
- resp_id_o  out  MSG_ID_SIZE  ID of the originating request.
- busy_o  out  1  state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_RSP, REPLY.
- IDLE, arbitration:
  - Only one FIFO non-empty: select it.
  - Both non-empty: select the one not granted last (last_grant register).
  - On selection, assert the pop in the same cycle, latch the head into cur_op/cur_data/cur_id, and update last_grant.
- Selected alloc:
  - size == 0, or rounding overflows DATA_W: latch resp_addr = 0 and go to REPLY. No core request.
  - Otherwise cur_data = (size + ALIGN_BYTES-1) & ~(ALIGN_BYTES-1); go to ISSUE.
  - Overflow: size > 2^DATA_W − ALIGN_BYTES. Detect it with a DATA_W+1-bit sum.
- Selected free:
  - address == 0: pop only, stay in IDLE. last_grant still updates.
  - address unaligned (low log2(ALIGN_BYTES) bits nonzero): also dropped. The drop counts as a grant.
  - Otherwise go to ISSUE.
- ISSUE: core_req_val_o = 1 with stable core_req_o until core_req_rdy_i is high, then go to WAIT_RSP.
- WAIT_RSP: core_rsp_rdy_o = 1.
  - On core_rsp_val_i for an alloc: latch resp_addr = ok ? addr : 0, go to REPLY.
  - On core_rsp_val_i for a free: go to IDLE.
- REPLY: resp_val_o = 1 with stable resp_addr_o/resp_id_o until resp_rdy_i is high, then go to IDLE.
- Reset values: state IDLE, last_grant = FREE (so alloc wins the first tie), latched data 0. All valid, ready and pop outputs are 0; busy_o = 0.
- Reset mid-operation abandons the latched request with no retry. Any core response that arrives afterwards is not accepted until WAIT_RSP is entered again.

## Timing
- At most one pop per cycle, and only in IDLE, so there is never a simultaneous alloc+free pop.
- Pops are combinational from the empty flags and state; they are never asserted while a FIFO is empty.
- Minimum alloc latency, pop to resp_val_o:
  - Cycle 0: pop.
  - Cycle 1: ISSUE, with rdy = 1.
  - Cycle 2: WAIT_RSP; the response can arrive in this cycle.
  - Cycle 3: REPLY.
- Zero-size alloc: pop in cycle 0, resp_val_o in cycle 1.
- Throughput: the next selection happens in the cycle after the REPLY handshake, or after the free response.
- core_req_o, resp_addr_o and resp_id_o are driven from registers. They are valid only while their valid signal is high and read 0 otherwise.

## Structure
- Package falafel_pkg gets:
  - core_op_e {CORE_ALLOC, CORE_FREE}.
  - core_req_t {core_op_e op; logic [DATA_W-1:0] data; logic [MSG_ID_SIZE-1:0] id;}.
  - dispatch_state_e.
  - ALIGN_BYTES.
  - A function align_up(size) that returns {overflow, aligned}.
- The block is single-module. No sub-module: the arbitration is two requesters with one history bit.

## Test plan
- Alloc size 13, id 5, core rdy = 1, ok = 1, addr 0x100 → core_req_o = {ALLOC, 16, 5}; resp 0x100 / id 5 appears 3 cycles after the pop.
- Both FIFOs continuously non-empty after reset → grants alternate alloc, free, alloc, free; exactly one pop per selection.
- Alloc size 0, id 9 → resp_addr_o = 0, id 9 in the next cycle; core_req_val_o never asserts.
- Alloc size 2^DATA_W−1 → reply 0 with no core request. Core ok = 0 for size 64 → reply 0.
- Free addresses 0 and 0x104 → popped with no core request. Free 0x200 → core_req_o = {FREE, 0x200}; no resp_val_o.
- core_req_rdy_i held low for 4 cycles, then resp_rdy_i held low for 3 cycles → payloads stay stable throughout. Assert rst_i during WAIT_RSP → all outputs go to 0 and the state is IDLE at once.

Source files
------------

// File: rtl/falafel_pkg.sv
// falafel_pkg: shared types and constants for the falafel request dispatcher.
//   DATA_W       width of the size and address fields
//   MSG_ID_SIZE  width of the request ID
//   ALIGN_BYTES  allocation granule (power of two)
//   core_op_e, core_req_t, dispatch_state_e, align_up()
package falafel_pkg;

    localparam int DATA_W      = 16;
    localparam int MSG_ID_SIZE = 4;
    localparam int ALIGN_BYTES = 8;

    localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'(ALIGN_BYTES - 1);

    typedef enum logic {
        CORE_ALLOC = 1'b0,
        CORE_FREE  = 1'b1
    } core_op_e;

    typedef struct packed {
        core_op_e                op;
        logic [DATA_W-1:0]       data;
        logic [MSG_ID_SIZE-1:0]  id;
    } core_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        REPLY
    } dispatch_state_e;

    // Rounds size up to the granule. Bit DATA_W of the result is the carry
    // out of the DATA_W+1-bit sum, i.e. the rounded size does not fit.
    function automatic logic [DATA_W:0] align_up(input logic [DATA_W-1:0] size);
        logic [DATA_W:0] sum;
        sum = {1'b0, size} + {1'b0, ALIGN_MASK};
        return {sum[DATA_W], sum[DATA_W-1:0] & ~ALIGN_MASK};
    endfunction

endpackage

// File: rtl/falafel_req_dispatcher.sv
// falafel_req_dispatcher: drains the alloc and free request FIFOs, arbitrates
// fairly between them, filters trivial requests and issues one request at a
// time to the allocator core; alloc results are returned with their ID.
//   clk_i, rst_i                      clock, async active-high reset
//   alloc_fifo_*                      FWFT alloc FIFO (size, id), pop
//   free_fifo_*                       FWFT free FIFO (address), pop
//   core_req_val_o/rdy_i, core_req_o  request channel to the core
//   core_rsp_val_i/rdy_o, addr, ok    response channel from the core
//   resp_val_o/rdy_i, addr, id        alloc result channel (addr 0 = failure)
//   busy_o                            dispatcher is not idle
module falafel_req_dispatcher
    import falafel_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    alloc_fifo_empty_i,
    output logic                    alloc_fifo_pop_o,
    input  logic [DATA_W-1:0]       alloc_fifo_dout_size_i,
    input  logic [MSG_ID_SIZE-1:0]  alloc_fifo_dout_id_i,
    input  logic                    free_fifo_empty_i,
    output logic                    free_fifo_pop_o,
    input  logic [DATA_W-1:0]       free_fifo_dout_i,
    output logic                    core_req_val_o,
    input  logic                    core_req_rdy_i,
    output core_req_t               core_req_o,
    input  logic                    core_rsp_val_i,
    output logic                    core_rsp_rdy_o,
    input  logic [DATA_W-1:0]       core_rsp_addr_i,
    input  logic                    core_rsp_ok_i,
    output logic                    resp_val_o,
    input  logic                    resp_rdy_i,
    output logic [DATA_W-1:0]       resp_addr_o,
    output logic [MSG_ID_SIZE-1:0]  resp_id_o,
    output logic                    busy_o
);

    dispatch_state_e          state_q, state_d;
    core_op_e                 last_grant;
    core_op_e                 cur_op;
    logic [DATA_W-1:0]        cur_data;
    logic [MSG_ID_SIZE-1:0]   cur_id;
    logic [DATA_W-1:0]        resp_addr;

    logic                     grant_alloc, grant_free;
    logic [DATA_W:0]          alloc_rounded;
    logic                     alloc_trivial, free_drop;

    // Two requesters, one history bit: on a tie the side not granted last wins.
    assign grant_alloc = !rst_i && (state_q == IDLE) && !alloc_fifo_empty_i &&
                         (free_fifo_empty_i || last_grant == CORE_FREE);
    assign grant_free  = !rst_i && (state_q == IDLE) && !free_fifo_empty_i &&
                         (alloc_fifo_empty_i || last_grant == CORE_ALLOC);

    assign alloc_rounded = align_up(alloc_fifo_dout_size_i);
    assign alloc_trivial = (alloc_fifo_dout_size_i == '0) || alloc_rounded[DATA_W];
    assign free_drop     = (free_fifo_dout_i == '0) ||
                           ((free_fifo_dout_i & ALIGN_MASK) != '0);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_alloc)     state_d = alloc_trivial ? REPLY : ISSUE;
                else if (grant_free) state_d = free_drop ? IDLE : ISSUE;
            end
            ISSUE:    if (core_req_rdy_i) state_d = WAIT_RSP;
            WAIT_RSP: if (core_rsp_val_i) state_d = (cur_op == CORE_ALLOC) ? REPLY : IDLE;
            REPLY:    if (resp_rdy_i)     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Request/response latches. A trivial alloc latches the aligned size
    // (possibly wrapped) but never issues it, and leaves resp_addr at 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= CORE_FREE;
            cur_op     <= CORE_ALLOC;
            cur_data   <= '0;
            cur_id     <= '0;
            resp_addr  <= '0;
        end else if (grant_alloc) begin
            last_grant <= CORE_ALLOC;
            cur_op     <= CORE_ALLOC;
            cur_data   <= alloc_rounded[DATA_W-1:0];
            cur_id     <= alloc_fifo_dout_id_i;
            resp_addr  <= '0;
        end else if (grant_free) begin
            last_grant <= CORE_FREE;
            cur_op     <= CORE_FREE;
            cur_data   <= free_fifo_dout_i;
            cur_id     <= '0;
        end else if (state_q == WAIT_RSP && core_rsp_val_i && cur_op == CORE_ALLOC) begin
            resp_addr  <= core_rsp_ok_i ? core_rsp_addr_i : '0;
        end
    end

    // Outputs: payloads are gated to 0 whenever their valid is low.
    always_comb begin
        alloc_fifo_pop_o = grant_alloc;
        free_fifo_pop_o  = grant_free;
        core_req_val_o   = (state_q == ISSUE);
        core_rsp_rdy_o   = (state_q == WAIT_RSP);
        resp_val_o       = (state_q == REPLY);
        busy_o           = (state_q != IDLE);
        core_req_o       = '0;
        resp_addr_o      = '0;
        resp_id_o        = '0;
        if (state_q == ISSUE) begin
            core_req_o.op   = cur_op;
            core_req_o.data = cur_data;
            core_req_o.id   = cur_id;
        end
        if (state_q == REPLY) begin
            resp_addr_o = resp_addr;
            resp_id_o   = cur_id;
        end
    end

endmodule

// File: tb/tb_falafel_req_dispatcher.sv
// tb_falafel_req_dispatcher: randomized bench with a transaction-level model.
// Inputs are driven 1 ns after the rising edge; outputs are sampled and the
// model advanced on the falling edge, so a handshake seen at the falling edge
// is the one that completes on the next rising edge.
module tb_falafel_req_dispatcher;
    import falafel_pkg::*;

    localparam int MAX_SIZE = (1 << DATA_W) - ALIGN_BYTES;

    typedef struct {
        logic [DATA_W-1:0]      size;
        logic [MSG_ID_SIZE-1:0] id;
    } alloc_item_t;

    logic                   clk = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   alloc_fifo_empty_i = 1'b1;
    logic                   alloc_fifo_pop_o;
    logic [DATA_W-1:0]      alloc_fifo_dout_size_i = '0;
    logic [MSG_ID_SIZE-1:0] alloc_fifo_dout_id_i = '0;
    logic                   free_fifo_empty_i = 1'b1;
    logic                   free_fifo_pop_o;
    logic [DATA_W-1:0]      free_fifo_dout_i = '0;
    logic                   core_req_val_o;
    logic                   core_req_rdy_i = 1'b0;
    core_req_t              core_req_o;
    logic                   core_rsp_val_i = 1'b0;
    logic                   core_rsp_rdy_o;
    logic [DATA_W-1:0]      core_rsp_addr_i = '0;
    logic                   core_rsp_ok_i = 1'b0;
    logic                   resp_val_o;
    logic                   resp_rdy_i = 1'b0;
    logic [DATA_W-1:0]      resp_addr_o;
    logic [MSG_ID_SIZE-1:0] resp_id_o;
    logic                   busy_o;

    falafel_req_dispatcher dut (
        .clk_i(clk), .rst_i(rst_i),
        .alloc_fifo_empty_i(alloc_fifo_empty_i), .alloc_fifo_pop_o(alloc_fifo_pop_o),
        .alloc_fifo_dout_size_i(alloc_fifo_dout_size_i), .alloc_fifo_dout_id_i(alloc_fifo_dout_id_i),
        .free_fifo_empty_i(free_fifo_empty_i), .free_fifo_pop_o(free_fifo_pop_o),
        .free_fifo_dout_i(free_fifo_dout_i),
        .core_req_val_o(core_req_val_o), .core_req_rdy_i(core_req_rdy_i), .core_req_o(core_req_o),
        .core_rsp_val_i(core_rsp_val_i), .core_rsp_rdy_o(core_rsp_rdy_o),
        .core_rsp_addr_i(core_rsp_addr_i), .core_rsp_ok_i(core_rsp_ok_i),
        .resp_val_o(resp_val_o), .resp_rdy_i(resp_rdy_i),
        .resp_addr_o(resp_addr_o), .resp_id_o(resp_id_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Bench-side FIFO contents and stimulus knobs.
    alloc_item_t       aq[$];
    logic [DATA_W-1:0] fq[$];
    bit en_rand = 0;
    bit stray   = 0;
    int core_rdy_pct = 100, resp_rdy_pct = 100;
    int rsp_delay_lo = 0, rsp_delay_hi = 0;
    int rsp_addr_k = -1, rsp_ok_k = -1;
    int rsp_cnt = 0;

    // Transaction-level model: at most one request in flight.
    bit                     outstanding;
    core_op_e               mlast;
    bit                     exp_req_valid;
    core_op_e               exp_req_op;
    logic [DATA_W-1:0]      exp_req_data;
    logic [MSG_ID_SIZE-1:0] exp_req_id;
    bit                     waiting;
    core_op_e               wait_op;
    logic [MSG_ID_SIZE-1:0] wait_id;
    bit                     exp_resp_valid;
    logic [DATA_W-1:0]      exp_resp_addr;
    logic [MSG_ID_SIZE-1:0] exp_resp_id;

    // Observations used by the hand-computed checks.
    int pop_cyc, resp_first_cyc, req_cnt, resp_cnt, req_stall, resp_stall;
    logic [DATA_W-1:0]      req_last_data, last_resp_addr;
    logic [MSG_ID_SIZE-1:0] req_last_id, last_resp_id;
    core_op_e               req_last_op;
    core_op_e               grants[$];
    bit                     resp_val_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_records();
        pop_cyc = -100; resp_first_cyc = -1; req_cnt = 0; resp_cnt = 0;
        req_stall = 0; resp_stall = 0; req_last_data = '0; req_last_id = '0;
        req_last_op = CORE_ALLOC; last_resp_addr = '1; last_resp_id = '1;
        grants.delete();
    endtask

    task automatic reset_model();
        aq.delete(); fq.delete();
        outstanding = 0; mlast = CORE_FREE; exp_req_valid = 0; waiting = 0;
        exp_resp_valid = 0; resp_val_prev = 0;
        core_rsp_val_i = 0; core_rsp_addr_i = '0; core_rsp_ok_i = 0;
        alloc_fifo_empty_i = 1; free_fifo_empty_i = 1;
        alloc_fifo_dout_size_i = '0; alloc_fifo_dout_id_i = '0; free_fifo_dout_i = '0;
    endtask

    function automatic alloc_item_t rand_alloc();
        alloc_item_t it;
        it.id = MSG_ID_SIZE'($urandom);
        case ($urandom_range(7))
            0: it.size = '0;
            1: it.size = 16'hFFFF;
            2: it.size = 16'hFFF9;
            3: it.size = 16'hFFF8;
            4: it.size = DATA_W'($urandom_range(1, 64));
            default: it.size = DATA_W'($urandom);
        endcase
        return it;
    endfunction

    function automatic logic [DATA_W-1:0] rand_free();
        case ($urandom_range(5))
            0: return '0;
            1: return DATA_W'({$urandom_range(0, 8191), 3'b000} | $urandom_range(1, 7));
            default: return DATA_W'({$urandom_range(1, 8191), 3'b000});
        endcase
    endfunction

    task automatic drive();
        if (en_rand) begin
            if (aq.size() < 3 && $urandom_range(99) < 40) aq.push_back(rand_alloc());
            if (fq.size() < 3 && $urandom_range(99) < 40) fq.push_back(rand_free());
        end
        alloc_fifo_empty_i     = (aq.size() == 0);
        alloc_fifo_dout_size_i = (aq.size() != 0) ? aq[0].size : '0;
        alloc_fifo_dout_id_i   = (aq.size() != 0) ? aq[0].id : '0;
        free_fifo_empty_i      = (fq.size() == 0);
        free_fifo_dout_i       = (fq.size() != 0) ? fq[0] : '0;
        core_req_rdy_i = ($urandom_range(99) < core_rdy_pct);
        resp_rdy_i     = ($urandom_range(99) < resp_rdy_pct);
        if (waiting) begin
            if (!core_rsp_val_i) begin
                if (rsp_cnt == 0) begin
                    core_rsp_val_i  = 1;
                    core_rsp_addr_i = (rsp_addr_k < 0) ? DATA_W'({$urandom_range(1, 8191), 3'b000})
                                                       : DATA_W'(rsp_addr_k);
                    core_rsp_ok_i   = (rsp_ok_k < 0) ? 1'($urandom) : 1'(rsp_ok_k);
                end else begin
                    rsp_cnt--;
                end
            end
        end else if (!stray) begin
            core_rsp_val_i = 0; core_rsp_addr_i = '0; core_rsp_ok_i = 0;
        end
    endtask

    task automatic sample_and_commit();
        core_req_t rq;
        bit a, f, exp_pa, exp_pf;
        int sz;
        rq = core_req_o;
        a = (aq.size() != 0);
        f = (fq.size() != 0);
        exp_pa = !outstanding && a && (!f || mlast == CORE_FREE);
        exp_pf = !outstanding && f && (!a || mlast == CORE_ALLOC);
        check("alloc_pop", alloc_fifo_pop_o, exp_pa);
        check("free_pop", free_fifo_pop_o, exp_pf);
        check("busy", busy_o, outstanding);
        check("core_req_val", core_req_val_o, exp_req_valid);
        if (core_req_val_o && exp_req_valid) begin
            check("core_req_op", rq.op, exp_req_op);
            check("core_req_data", rq.data, exp_req_data);
            if (exp_req_op == CORE_ALLOC) check("core_req_id", rq.id, exp_req_id);
        end else if (!core_req_val_o) begin
            check("core_req_idle_zero", rq, '0);
        end
        check("core_rsp_rdy", core_rsp_rdy_o, waiting);
        check("resp_val", resp_val_o, exp_resp_valid);
        if (resp_val_o && exp_resp_valid) begin
            check("resp_addr", resp_addr_o, exp_resp_addr);
            check("resp_id", resp_id_o, exp_resp_id);
        end else if (!resp_val_o) begin
            check("resp_idle_zero", {resp_addr_o, resp_id_o}, '0);
        end

        // Observations.
        if (core_req_val_o) begin
            req_cnt++; req_last_data = rq.data; req_last_id = rq.id; req_last_op = rq.op;
            if (!core_req_rdy_i) req_stall++;
        end
        if (resp_val_o && !resp_val_prev) resp_first_cyc = cyc;
        if (resp_val_o && !resp_rdy_i) resp_stall++;
        resp_val_prev = resp_val_o && !resp_rdy_i;

        // Commit handshakes that complete on the next rising edge.
        if (alloc_fifo_pop_o && a) begin
            alloc_item_t it;
            it = aq.pop_front();
            mlast = CORE_ALLOC; grants.push_back(CORE_ALLOC); pop_cyc = cyc;
            outstanding = 1;
            sz = int'(it.size);
            if (sz == 0 || sz > MAX_SIZE) begin
                exp_resp_valid = 1; exp_resp_addr = '0; exp_resp_id = it.id;
            end else begin
                exp_req_valid = 1; exp_req_op = CORE_ALLOC;
                exp_req_data = DATA_W'(((sz + ALIGN_BYTES - 1) / ALIGN_BYTES) * ALIGN_BYTES);
                exp_req_id = it.id;
            end
        end
        if (free_fifo_pop_o && f) begin
            logic [DATA_W-1:0] ad;
            ad = fq.pop_front();
            mlast = CORE_FREE; grants.push_back(CORE_FREE); pop_cyc = cyc;
            if (ad != 0 && (int'(ad) % ALIGN_BYTES) == 0) begin
                outstanding = 1;
                exp_req_valid = 1; exp_req_op = CORE_FREE; exp_req_data = ad; exp_req_id = '0;
            end
        end
        if (core_req_val_o && core_req_rdy_i && exp_req_valid) begin
            exp_req_valid = 0; waiting = 1; wait_op = exp_req_op; wait_id = exp_req_id;
            rsp_cnt = $urandom_range(rsp_delay_lo, rsp_delay_hi);
        end
        if (core_rsp_val_i && core_rsp_rdy_o && waiting) begin
            waiting = 0;
            if (wait_op == CORE_ALLOC) begin
                exp_resp_valid = 1;
                exp_resp_addr = core_rsp_ok_i ? core_rsp_addr_i : '0;
                exp_resp_id = wait_id;
            end else begin
                outstanding = 0;
            end
        end
        if (resp_val_o && resp_rdy_i && exp_resp_valid) begin
            exp_resp_valid = 0; outstanding = 0; resp_cnt++;
            last_resp_addr = resp_addr_o; last_resp_id = resp_id_o;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        drive();
        @(negedge clk);
        sample_and_commit();
        cyc++;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = !outstanding && aq.size() == 0 && fq.size() == 0;
        end
        check({name, "_done"}, done, 1);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_i = 1;
        reset_model();
        #1;
        check("rst_core_req_val", core_req_val_o, 0);
        check("rst_core_req", core_req_o, '0);
        check("rst_core_rsp_rdy", core_rsp_rdy_o, 0);
        check("rst_resp", {resp_val_o, resp_addr_o, resp_id_o}, '0);
        check("rst_pops", {alloc_fifo_pop_o, free_fifo_pop_o}, '0);
        check("rst_busy", busy_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_i = 0;
        @(negedge clk);
        sample_and_commit();
        cyc++;
    endtask

    initial begin
        alloc_item_t it;
        bit hit;
        reset_model();
        clear_records();
        reset_dut();

        // Alloc 13 -> granule 16, response 0x100 three cycles after the pop.
        rsp_addr_k = 'h100; rsp_ok_k = 1;
        clear_records();
        it.size = 13; it.id = 5; aq.push_back(it);
        run_until_idle("a13", 30);
        check("a13_req_data", req_last_data, 16);
        check("a13_req_id", req_last_id, 5);
        check("a13_resp_addr", last_resp_addr, 'h100);
        check("a13_resp_id", last_resp_id, 5);
        check("a13_latency", resp_first_cyc - pop_cyc, 3);

        // Zero-size alloc: reply 0 the next cycle, no core request.
        clear_records();
        it.size = 0; it.id = 9; aq.push_back(it);
        run_until_idle("zero", 10);
        check("zero_req_cnt", req_cnt, 0);
        check("zero_resp_addr", last_resp_addr, 0);
        check("zero_resp_id", last_resp_id, 9);
        check("zero_latency", resp_first_cyc - pop_cyc, 1);

        // Rounding overflow: reply 0 without a core request.
        clear_records();
        it.size = 16'hFFFF; it.id = 3; aq.push_back(it);
        run_until_idle("ovf", 10);
        check("ovf_req_cnt", req_cnt, 0);
        check("ovf_resp_addr", last_resp_addr, 0);

        // Core refuses size 64: reply 0.
        clear_records();
        rsp_addr_k = 'h340; rsp_ok_k = 0;
        it.size = 64; it.id = 7; aq.push_back(it);
        run_until_idle("nok", 30);
        check("nok_req_data", req_last_data, 64);
        check("nok_resp_addr", last_resp_addr, 0);
        check("nok_resp_id", last_resp_id, 7);

        // NULL and unaligned frees are popped and dropped.
        clear_records();
        fq.push_back('0); fq.push_back(16'h0104);
        run_until_idle("fdrop", 10);
        check("fdrop_req_cnt", req_cnt, 0);
        check("fdrop_grants", grants.size(), 2);

        // Aligned free reaches the core; nothing on the result channel.
        clear_records();
        fq.push_back(16'h0200);
        run_until_idle("free", 30);
        check("free_req_data", req_last_data, 'h200);
        check("free_req_op", req_last_op, CORE_FREE);
        check("free_resp_cnt", resp_cnt, 0);

        // Both FIFOs non-empty after reset: grants alternate, alloc first.
        reset_dut();
        clear_records();
        rsp_addr_k = -1; rsp_ok_k = -1;
        for (int i = 0; i < 4; i++) begin
            it.size = DATA_W'(8 * (i + 1)); it.id = MSG_ID_SIZE'(i + 1);
            aq.push_back(it);
            fq.push_back(DATA_W'('h208 + 8 * i));
        end
        run_until_idle("alt", 100);
        check("alt_grant_cnt", grants.size(), 8);
        if (grants.size() >= 4) begin
            check("alt_g0", grants[0], CORE_ALLOC);
            check("alt_g1", grants[1], CORE_FREE);
            check("alt_g2", grants[2], CORE_ALLOC);
            check("alt_g3", grants[3], CORE_FREE);
        end

        // Back-pressure: core stalls 4 cycles, downstream stalls 3 cycles.
        clear_records();
        core_rdy_pct = 0; resp_rdy_pct = 0;
        it.size = 40; it.id = 2; aq.push_back(it);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (req_stall >= 4)  core_rdy_pct = 100;
            if (resp_stall >= 3) resp_rdy_pct = 100;
            step();
            hit = (i > 1) && !outstanding && aq.size() == 0;
        end
        check("stall_done", hit, 1);
        check("stall_req_cycles", req_stall, 4);
        check("stall_req_total", req_cnt, 5);
        check("stall_resp_cycles", resp_stall, 3);
        check("stall_req_data", req_last_data, 40);
        core_rdy_pct = 100; resp_rdy_pct = 100;

        // Reset while waiting for the core response.
        clear_records();
        rsp_delay_lo = 20; rsp_delay_hi = 20;
        it.size = 24; it.id = 3; aq.push_back(it);
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            step();
            hit = waiting;
        end
        check("rstw_reached", hit, 1);
        reset_dut();
        rsp_delay_lo = 0; rsp_delay_hi = 2;
        // A late response from the abandoned request must not be accepted.
        stray = 1; core_rsp_val_i = 1; core_rsp_addr_i = 16'h0AA8; core_rsp_ok_i = 1;
        repeat (3) step();
        stray = 0;
        clear_records();
        it.size = 8; it.id = 6; aq.push_back(it);
        fq.push_back(16'h0300);
        run_until_idle("rstw", 60);
        check("rstw_resp_cnt", resp_cnt, 1);
        if (grants.size() != 0) check("rstw_first_grant", grants[0], CORE_ALLOC);

        // Randomized traffic.
        en_rand = 1;
        for (int b = 0; b < 15; b++) begin
            core_rdy_pct = $urandom_range(30, 100);
            resp_rdy_pct = $urandom_range(30, 100);
            rsp_delay_lo = 0; rsp_delay_hi = $urandom_range(0, 4);
            repeat (200) step();
        end
        en_rand = 0;
        core_rdy_pct = 100; resp_rdy_pct = 100;
        run_until_idle("drain", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
